// File: rtl/vxe_reg_rd_port_if.sv
// Purpose: bundles the write port and the handshaked read port of vxe_reg_rd_port.
// Latency: none, signal container only.
// Backpressure: rd_rdy/rd_req on the request side, rd_vld/rd_ack on the response side.
interface vxe_reg_rd_port_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4
);
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  rd_req;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  rd_rdy;
   logic                  rd_vld;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_err;
   logic                  rd_ack;

   // Host / read-out logic side.
   modport master (
      output wr_en, wr_addr, wr_data, rd_req, rd_addr, rd_ack,
      input  rd_rdy, rd_vld, rd_data, rd_err
   );

   // Register bank side.
   modport slave (
      input  wr_en, wr_addr, wr_data, rd_req, rd_addr, rd_ack,
      output rd_rdy, rd_vld, rd_data, rd_err
   );
endinterface

// File: rtl/vxe_reg_rd_port.sv
// Purpose: NREGS-entry register bank with a buffered request/ack read port (2-entry response FIFO).
// Latency: write visible to reads accepted next cycle; read response valid the cycle after acceptance.
// Backpressure: rd_rdy drops when both FIFO entries are full; head data held stable until rd_ack.
// Option: define VXE_REG_RD_PORT_BYPASS_EN to forward same-edge write data to a colliding read.
module vxe_reg_rd_port #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 4,
   parameter int                    NREGS      = 16,
   parameter logic [DATA_WIDTH-1:0] RST_VALUE  = 32'hdead_beef
) (
   input logic               clk,
   input logic               nrst,
   vxe_reg_rd_port_if.slave  bus
);

   typedef struct packed {
      logic                  err;
      logic [DATA_WIDTH-1:0] data;
   } rsp_t;

   logic [DATA_WIDTH-1:0] regs [NREGS];

   logic [DATA_WIDTH-1:0] rd_word;
   logic                  rd_hit;

   rsp_t       fifo [2];
   logic       wr_ptr;
   logic       rd_ptr;
   logic [1:0] count;
   rsp_t       head;
   logic       push;
   logic       pop;

   // Register bank: out-of-range write addresses match no entry and are dropped.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= RST_VALUE;
      end else if (bus.wr_en) begin
         for (int i = 0; i < NREGS; i++) begin
            if (bus.wr_addr == ADDR_WIDTH'(i)) regs[i] <= bus.wr_data;
         end
      end
   end

   // Read mux: rd_hit marks an implemented address; misses return RST_VALUE.
   always_comb begin
      rd_word = RST_VALUE;
      rd_hit  = 1'b0;
      for (int i = 0; i < NREGS; i++) begin
         if (bus.rd_addr == ADDR_WIDTH'(i)) begin
            rd_word = regs[i];
            rd_hit  = 1'b1;
         end
      end
`ifdef VXE_REG_RD_PORT_BYPASS_EN
      if (rd_hit && bus.wr_en && (bus.wr_addr == bus.rd_addr)) rd_word = bus.wr_data;
`endif
   end

   // Handshakes; rd_rdy looks only at the occupancy so it never combinationally depends on rd_ack.
   always_comb begin
      bus.rd_rdy = (count != 2'd2);
      bus.rd_vld = (count != 2'd0);
      push       = bus.rd_req && bus.rd_rdy;
      pop        = bus.rd_vld && bus.rd_ack;
   end

   // Response FIFO: data is captured at acceptance, so later writes cannot change queued entries.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         fifo[0] <= '{err: 1'b0, data: RST_VALUE};
         fifo[1] <= '{err: 1'b0, data: RST_VALUE};
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         count   <= 2'd0;
      end else begin
         if (push) begin
            fifo[wr_ptr] <= '{err: ~rd_hit, data: rd_word};
            wr_ptr       <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Head presentation: idle port shows RST_VALUE with no error.
   always_comb begin
      head        = fifo[rd_ptr];
      bus.rd_data = bus.rd_vld ? head.data : RST_VALUE;
      bus.rd_err  = bus.rd_vld & head.err;
   end

endmodule

// File: tb/tb_vxe_reg_rd_port.sv
// Directed bench for vxe_reg_rd_port with a response scoreboard (NREGS=12 to exercise out-of-range).
// Expected responses are pushed at request acceptance and popped when the DUT hands a response over.
// Collision expectation follows VXE_REG_RD_PORT_BYPASS_EN in the same way as the design build.
module tb_vxe_reg_rd_port;
   localparam int          NREGS = 12;
   localparam logic [31:0] RSTV  = 32'hdead_beef;
`ifdef VXE_REG_RD_PORT_BYPASS_EN
   localparam logic [31:0] COLL_EXP = 32'hbebe_0000;
`else
   localparam logic [31:0] COLL_EXP = 32'hdead_beef;
`endif

   logic clk  = 1'b0;
   logic nrst = 1'b0;
   always #5 clk = ~clk;

   vxe_reg_rd_port_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus ();

   vxe_reg_rd_port #(
      .DATA_WIDTH(32), .ADDR_WIDTH(4), .NREGS(NREGS), .RST_VALUE(RSTV)
   ) dut (
      .clk(clk), .nrst(nrst), .bus(bus)
   );

   logic [32:0] sb [$];
   logic [31:0] mdl [16];
   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Response monitor: a handshake seen mid-cycle completes on the next rising edge.
   always @(negedge clk) begin
      if (nrst && bus.rd_vld && bus.rd_ack) begin
         checks++;
         assert (sb.size() > 0) else begin
            failures++;
            $error("FAIL unexp_rsp observed=%h expected=none", {bus.rd_err, bus.rd_data});
         end
         if (sb.size() > 0) chk("rsp", {bus.rd_err, bus.rd_data}, sb.pop_front());
      end
   end

   task automatic model_reset();
      for (int i = 0; i < 16; i++) mdl[i] = RSTV;
   endtask

   // One clock cycle of stimulus; acc reports whether the read request is accepted this cycle.
   task automatic cyc(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                      input logic rq, input logic [3:0] ra, input logic ack, output logic acc);
      logic [31:0] d;
      bus.wr_en   = we;
      bus.wr_addr = wa;
      bus.wr_data = wd;
      bus.rd_req  = rq;
      bus.rd_addr = ra;
      bus.rd_ack  = ack;
      @(negedge clk);
      acc = rq && bus.rd_rdy;
      if (acc) begin
         if (ra < NREGS) begin
            d = mdl[ra];
`ifdef VXE_REG_RD_PORT_BYPASS_EN
            if (we && wa == ra) d = wd;
`endif
            sb.push_back({1'b0, d});
         end else begin
            sb.push_back({1'b1, RSTV});
         end
      end
      if (we && wa < NREGS) mdl[wa] = wd;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic acc;
      logic got;
      model_reset();
      bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
      bus.rd_req = 0; bus.rd_addr = 0; bus.rd_ack = 0;

      // Reset state
      repeat (4) @(posedge clk);
      #1;
      chk("rst_rdy",  {32'd0, bus.rd_rdy}, 33'd1);
      chk("rst_vld",  {32'd0, bus.rd_vld}, 33'd0);
      chk("rst_data", {1'b0, bus.rd_data}, {1'b0, RSTV});
      chk("rst_err",  {32'd0, bus.rd_err}, 33'd0);
      nrst = 1'b1;
      cyc(0, 0, 0, 0, 0, 1, acc);

      // First read after reset, one-cycle latency
      cyc(0, 0, 0, 1, 4'd3, 1, acc);
      chk("rd3_vld",  {32'd0, bus.rd_vld}, 33'd1);
      chk("rd3_data", {bus.rd_err, bus.rd_data}, {1'b0, 32'hdead_beef});
      cyc(0, 0, 0, 0, 0, 1, acc);

      // Write then read next cycle
      cyc(1, 4'd2, 32'hfefe_0000, 0, 0, 1, acc);
      cyc(0, 0, 0, 1, 4'd2, 1, acc);
      chk("wr_rd2", {bus.rd_err, bus.rd_data}, {1'b0, 32'hfefe_0000});

      // Back-to-back reads 0..15, one per cycle (12..15 out of range)
      for (int a = 0; a < 16; a++) begin
         cyc(0, 0, 0, 1, 4'(a), 1, acc);
         chk("b2b_acc", {32'd0, acc}, 33'd1);
      end
      cyc(0, 0, 0, 0, 0, 1, acc);
      cyc(0, 0, 0, 0, 0, 1, acc);
      chk("b2b_drain", 33'(sb.size()), 33'd0);

      // Backpressure: two accepted, third held
      cyc(0, 0, 0, 1, 4'd1, 0, acc);
      chk("bp_acc1", {32'd0, acc}, 33'd1);
      cyc(0, 0, 0, 1, 4'd2, 0, acc);
      chk("bp_acc2", {32'd0, acc}, 33'd1);
      cyc(0, 0, 0, 1, 4'd3, 0, acc);
      chk("bp_acc3_held", {32'd0, acc}, 33'd0);
      chk("bp_rdy", {32'd0, bus.rd_rdy}, 33'd0);
      chk("bp_hold", {bus.rd_err, bus.rd_data}, {1'b0, 32'hdead_beef});
      cyc(0, 0, 0, 1, 4'd3, 0, acc);
      chk("bp_hold2", {bus.rd_err, bus.rd_data}, {1'b0, 32'hdead_beef});
      got = 1'b0;
      for (int t = 0; t < 5 && !got; t++) begin
         cyc(0, 0, 0, 1, 4'd3, 1, acc);
         got = acc;
      end
      chk("bp_acc3_late", {32'd0, got}, 33'd1);
      repeat (3) cyc(0, 0, 0, 0, 0, 1, acc);
      chk("bp_drain", 33'(sb.size()), 33'd0);

      // Out-of-range write and read
      cyc(1, 4'd13, 32'h1234_5678, 0, 0, 1, acc);
      cyc(0, 0, 0, 1, 4'd13, 1, acc);
      chk("oor_rsp", {bus.rd_err, bus.rd_data}, {1'b1, 32'hdead_beef});
      for (int a = 0; a < NREGS; a++) cyc(0, 0, 0, 1, 4'(a), 1, acc);

      // Same-edge write/read collision on addr 5
      cyc(1, 4'd5, 32'hbebe_0000, 1, 4'd5, 1, acc);
      chk("coll", {bus.rd_err, bus.rd_data}, {1'b0, COLL_EXP});
      cyc(0, 0, 0, 1, 4'd5, 1, acc);
      chk("coll_after", {bus.rd_err, bus.rd_data}, {1'b0, 32'hbebe_0000});
      repeat (2) cyc(0, 0, 0, 0, 0, 1, acc);
      chk("coll_drain", 33'(sb.size()), 33'd0);

      // Reset with two responses queued
      cyc(0, 0, 0, 1, 4'd2, 0, acc);
      cyc(0, 0, 0, 1, 4'd5, 0, acc);
      chk("mid_full", {32'd0, bus.rd_rdy}, 33'd0);
      bus.rd_req = 1'b0;
      nrst = 1'b0;
      #1;
      chk("mid_vld",  {32'd0, bus.rd_vld}, 33'd0);
      chk("mid_rdy",  {32'd0, bus.rd_rdy}, 33'd1);
      chk("mid_data", {1'b0, bus.rd_data}, {1'b0, RSTV});
      sb.delete();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      nrst = 1'b1;
      for (int t = 0; t < 3; t++) begin
         cyc(0, 0, 0, 0, 0, 1, acc);
         chk("post_rst_idle", {32'd0, bus.rd_vld}, 33'd0);
      end
      cyc(0, 0, 0, 1, 4'd2, 1, acc);
      chk("post_rst_r2", {bus.rd_err, bus.rd_data}, {1'b0, 32'hdead_beef});
      cyc(0, 0, 0, 1, 4'd5, 1, acc);
      chk("post_rst_r5", {bus.rd_err, bus.rd_data}, {1'b0, 32'hdead_beef});
      repeat (2) cyc(0, 0, 0, 0, 0, 1, acc);
      chk("final_drain", 33'(sb.size()), 33'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
